ahblite_slave_mux: RTL and testbench

//  Response side of the AHB-Lite interconnect: captures the address-phase slave selects and routes the

---
 rtl/ahblite_slave_mux.sv | 125 ++++++++++++
 tb/tb_ahblite_slave_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer with a built-in default slave.
// Captures the address-phase slave selects. In the data phase it routes the
// selected slave's ready, response and read data back to the master. Active
// transfers that hit no enabled port receive a two-cycle ERROR response.
module ahblite_slave_mux #(
  parameter bit          Port0_en  = 1'b1,
  parameter bit          Port1_en  = 1'b0,
  parameter bit          Port2_en  = 1'b0,
  parameter bit          Port3_en  = 1'b0,
  parameter bit          Port4_en  = 1'b0,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic        P1_HSEL,
  input  logic        P1_HREADYOUT,
  input  logic        P1_HRESP,
  input  logic [31:0] P1_HRDATA,
  input  logic        P2_HSEL,
  input  logic        P2_HREADYOUT,
  input  logic        P2_HRESP,
  input  logic [31:0] P2_HRDATA,
  input  logic        P3_HSEL,
  input  logic        P3_HREADYOUT,
  input  logic        P3_HRESP,
  input  logic [31:0] P3_HRDATA,
  input  logic        P4_HSEL,
  input  logic        P4_HREADYOUT,
  input  logic        P4_HRESP,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [4:0] en_sel;
  logic [4:0] pri_sel;
  logic [4:0] sel_q;
  logic       unmapped;
  logic       unused;

  // Only HTRANS[1] separates active transfers from IDLE/BUSY.
  assign unused = HTRANS[0];

  // Mask the decoder selects with the port enables, then keep only the
  // lowest set bit.
  always_comb begin
    en_sel   = {P4_HSEL & Port4_en, P3_HSEL & Port3_en, P2_HSEL & Port2_en,
                P1_HSEL & Port1_en, P0_HSEL & Port0_en};
    pri_sel  = en_sel & (~en_sel + 5'd1);
    unmapped = (en_sel == '0) & HTRANS[1];
  end

  // Default-slave next state. ERR1 always advances because the master is
  // stalled in it. The other states advance only on an address-phase capture.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (HREADY && unmapped) state_next = ERR1;
      ERR1:    state_next = ERR2;
      ERR2:    if (HREADY) state_next = unmapped ? ERR1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Default-slave state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_next;
  end

  // Data-phase select register. It is cleared whenever the default slave
  // owns the next data phase, so the slave inputs cannot reach the outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= (state_next == IDLE) ? pri_sel : '0;
  end

  // Response mux. The error states take precedence. With nothing selected,
  // the mux returns a zero-wait OKAY response with zero data.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    if (state != IDLE) begin
      HREADYOUT = (state == ERR2);
      HRESP     = 1'b1;
      HRDATA    = ERR_RDATA;
    end else if (sel_q[0]) begin
      HREADYOUT = P0_HREADYOUT;
      HRESP     = P0_HRESP;
      HRDATA    = P0_HRDATA;
    end else if (sel_q[1]) begin
      HREADYOUT = P1_HREADYOUT;
      HRESP     = P1_HRESP;
      HRDATA    = P1_HRDATA;
    end else if (sel_q[2]) begin
      HREADYOUT = P2_HREADYOUT;
      HRESP     = P2_HRESP;
      HRDATA    = P2_HRDATA;
    end else if (sel_q[3]) begin
      HREADYOUT = P3_HREADYOUT;
      HRESP     = P3_HRESP;
      HRDATA    = P3_HRDATA;
    end else if (sel_q[4]) begin
      HREADYOUT = P4_HREADYOUT;
      HRESP     = P4_HRESP;
      HRDATA    = P4_HRDATA;
    end
  end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Testbench for ahblite_slave_mux. A transaction-level model predicts the
// response on every cycle. Directed sequences add literal expectations.
module tb_ahblite_slave_mux;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam bit   [4:0]  PORT_EN  = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  htrans;
  logic [4:0]  hsel;
  logic [4:0]  s_ready;
  logic [4:0]  s_resp;
  logic [31:0] s_data [5];
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int errors = 0;
  int checks = 0;

  // Model state: index of the slave owning the data phase (-1 = none) and
  // the number of error-response cycles still to come (2, 1 or 0).
  int m_sel = -1;
  int m_err = 0;

  always #5 clk = ~clk;

  ahblite_slave_mux #(
    .Port0_en (1'b1),
    .Port1_en (1'b0),
    .Port2_en (1'b0),
    .Port3_en (1'b0),
    .Port4_en (1'b1),
    .ERR_RDATA(ERR_DATA)
  ) dut (
    .HCLK        (clk),
    .HRESETn     (rst_n),
    .HREADY      (hreadyout),
    .HTRANS      (htrans),
    .P0_HSEL     (hsel[0]),
    .P0_HREADYOUT(s_ready[0]),
    .P0_HRESP    (s_resp[0]),
    .P0_HRDATA   (s_data[0]),
    .P1_HSEL     (hsel[1]),
    .P1_HREADYOUT(s_ready[1]),
    .P1_HRESP    (s_resp[1]),
    .P1_HRDATA   (s_data[1]),
    .P2_HSEL     (hsel[2]),
    .P2_HREADYOUT(s_ready[2]),
    .P2_HRESP    (s_resp[2]),
    .P2_HRDATA   (s_data[2]),
    .P3_HSEL     (hsel[3]),
    .P3_HREADYOUT(s_ready[3]),
    .P3_HRESP    (s_resp[3]),
    .P3_HRDATA   (s_data[3]),
    .P4_HSEL     (hsel[4]),
    .P4_HREADYOUT(s_ready[4]),
    .P4_HRESP    (s_resp[4]),
    .P4_HRDATA   (s_data[4]),
    .HREADYOUT   (hreadyout),
    .HRESP       (hresp),
    .HRDATA      (hrdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string tag, input logic r, input logic e, input logic [31:0] d);
    check({tag, "_ready"}, {31'd0, hreadyout}, {31'd0, r});
    check({tag, "_resp"},  {31'd0, hresp},     {31'd0, e});
    check({tag, "_data"},  hrdata, d);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected {ready, resp, data}, derived from the model state.
  function automatic logic [33:0] model_out();
    if (m_err == 2) return {1'b0, 1'b1, ERR_DATA};
    if (m_err == 1) return {1'b1, 1'b1, ERR_DATA};
    if (m_sel >= 0) return {s_ready[m_sel], s_resp[m_sel], s_data[m_sel]};
    return {1'b1, 1'b0, 32'h0};
  endfunction

  // Model update. An address phase is accepted whenever the model's own
  // predicted ready is high.
  always @(posedge clk or negedge rst_n) begin
    logic [33:0] e;
    int idx;
    if (!rst_n) begin
      m_sel = -1;
      m_err = 0;
    end else begin
      e = model_out();
      if (m_err == 2) begin
        m_err = 1;
      end else if (e[33]) begin
        idx = -1;
        for (int i = 4; i >= 0; i--)
          if (hsel[i] && PORT_EN[i]) idx = i;
        if (idx < 0 && htrans[1]) begin
          m_err = 2;
          m_sel = -1;
        end else begin
          m_err = 0;
          m_sel = idx;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [33:0] e;
    e = model_out();
    check("cmp_ready", {31'd0, hreadyout}, {31'd0, e[33]});
    check("cmp_resp",  {31'd0, hresp},     {31'd0, e[32]});
    check("cmp_data",  hrdata, e[31:0]);
  end

  initial begin
    htrans  = 2'b00;
    hsel    = '0;
    s_ready = '1;
    s_resp  = '0;
    for (int i = 0; i < 5; i++) s_data[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    lit("reset", 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;

    // P0 transfer with two wait states; a P4 select during the wait is ignored.
    htrans = 2'b10; hsel = 5'b00001;
    cyc();
    s_data[0] = 32'h1234_5678; s_ready[0] = 1'b0;
    hsel = 5'b10000; s_data[4] = 32'h4444_0000;
    #1 lit("wait1", 1'b0, 1'b0, 32'h1234_5678);
    cyc();
    lit("wait2", 1'b0, 1'b0, 32'h1234_5678);
    s_ready[0] = 1'b1; hsel = '0; htrans = 2'b00;
    #1 lit("ready", 1'b1, 1'b0, 32'h1234_5678);
    cyc();
    lit("idle_after_p0", 1'b1, 1'b0, 32'h0);

    // Unmapped NONSEQ: two-cycle ERROR, then idle OKAY.
    htrans = 2'b10; hsel = '0;
    cyc();
    htrans = 2'b00;
    #1 lit("unm_err1", 1'b0, 1'b1, ERR_DATA);
    cyc();
    lit("unm_err2", 1'b1, 1'b1, ERR_DATA);
    cyc();
    lit("unm_okay", 1'b1, 1'b0, 32'h0);

    // Disabled port: NONSEQ errors, IDLE gives OKAY.
    hsel = 5'b00100; s_data[2] = 32'h2222_2222; htrans = 2'b10;
    cyc();
    htrans = 2'b00; hsel = '0;
    #1 lit("p2_err1", 1'b0, 1'b1, ERR_DATA);
    cyc();
    lit("p2_err2", 1'b1, 1'b1, ERR_DATA);
    hsel = 5'b00100; htrans = 2'b00;
    cyc();
    hsel = '0;
    #1 lit("p2_idle", 1'b1, 1'b0, 32'h0);
    cyc();
    lit("p2_idle2", 1'b1, 1'b0, 32'h0);

    // Back-to-back errors, then a P0 transfer captured in ERR2.
    htrans = 2'b10; hsel = '0;
    cyc();
    lit("b2b_err1a", 1'b0, 1'b1, ERR_DATA);
    cyc();
    lit("b2b_err2a", 1'b1, 1'b1, ERR_DATA);
    cyc();
    lit("b2b_err1b", 1'b0, 1'b1, ERR_DATA);
    cyc();
    lit("b2b_err2b", 1'b1, 1'b1, ERR_DATA);
    hsel = 5'b00001; s_data[0] = 32'hAAAA_5555; s_ready[0] = 1'b1;
    cyc();
    htrans = 2'b00; hsel = '0;
    #1 lit("p0_after_err", 1'b1, 1'b0, 32'hAAAA_5555);
    cyc();
    lit("idle_after_err", 1'b1, 1'b0, 32'h0);

    // Priority: P0 wins over P4. P4 alone is routed, including its ERROR response.
    hsel = 5'b10001; htrans = 2'b10;
    s_data[0] = 32'h1111_1111; s_data[4] = 32'h4444_4444; s_resp[4] = 1'b1;
    cyc();
    hsel = 5'b10000;
    #1 lit("prio_p0", 1'b1, 1'b0, 32'h1111_1111);
    cyc();
    hsel = '0; htrans = 2'b00;
    #1 lit("p4_route", 1'b1, 1'b1, 32'h4444_4444);
    cyc();
    lit("idle_after_p4", 1'b1, 1'b0, 32'h0);
    s_resp[4] = 1'b0;

    // Asynchronous reset during a P0 wait state.
    hsel = 5'b00001; htrans = 2'b10; s_ready[0] = 1'b0;
    cyc();
    hsel = '0; htrans = 2'b00;
    #1 lit("hold_before_rst", 1'b0, 1'b0, 32'h1111_1111);
    #2 rst_n = 1'b0;
    #1 lit("rst_mid_wait", 1'b1, 1'b0, 32'h0);
    cyc();
    rst_n = 1'b1; s_ready[0] = 1'b1;
    cyc();
    lit("post_rst_idle", 1'b1, 1'b0, 32'h0);

    // Asynchronous reset while in ERR1.
    htrans = 2'b10; hsel = '0;
    cyc();
    htrans = 2'b00;
    #1 lit("err1_before_rst", 1'b0, 1'b1, ERR_DATA);
    #2 rst_n = 1'b0;
    #1 lit("rst_in_err1", 1'b1, 1'b0, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    lit("post_rst_err", 1'b1, 1'b0, 32'h0);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
